alu_seq_n_bits: RTL and testbench

Sequential, parametrised successor to the combinational N-bit ALU. It adds a start/busy/done handshake, registered result and flags, and true iterative multiply and divide/modulo units, which replace the single-cycle `/` and `%` operators. It sits between the operand/opcode source (button-driven operation selector or a future register file) and the 7-segment/flag outputs, and is the datapath core for wider boards (N = 4..32).

---
 rtl/alu_seq_n_bits_pkg.sv | 33 +++
 rtl/alu_seq_n_bits_iter_muldiv.sv | 88 ++++++++
 rtl/ripple_carry_adder_N_bits.sv | 26 ++
 rtl/alu_seq_n_bits.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_n_bits.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_seq_n_bits_pkg.sv
// Shared opcode/state definitions for the sequential N-bit ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int OP_MAX = 9;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LSR = 4'd5,
    OP_LSL = 4'd6,
    OP_MOD = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Opcodes above OP_MAX have no defined operation.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return int'(op) > OP_MAX;
  endfunction

endpackage

// File: rtl/alu_seq_n_bits_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
// Latency: N cycles after load; last is high during the final iteration cycle.
// Backpressure: none; load restarts the unit unconditionally.
// Ports: clk, rst_n; load/is_div/a/b start an operation; last flags the final
// step; prod_lo/prod_hi give the 2N-bit product, quot/rem the division result.
module iter_muldiv #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] prod_lo,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Accumulator layout: mul {partial product, remaining multiplier bits};
  // div {partial remainder, dividend bits shifting into quotient bits}.
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;
  logic [N-1:0]  opnd;       // multiplicand for mul, divisor for div
  logic          div_mode;
  logic          run;
  logic [CW-1:0] cnt;

  logic [N-1:0]  hi_nxt;
  logic [N-1:0]  lo_nxt;
  logic [N:0]    mul_sum;
  logic [N:0]    div_sh;
  logic [N+1:0]  div_diff;
  logic          div_fits;

  assign last = run && (cnt == CW'(N - 1));

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[N-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    div_fits = ~div_diff[N+1];
    if (div_mode) begin
      // The partial remainder stays below the divisor, so N bits hold it.
      hi_nxt = div_fits ? div_diff[N-1:0] : div_sh[N-1:0];
      lo_nxt = {acc_lo[N-2:0], div_fits};
    end else begin
      // Shift right with the adder carry entering the top of the accumulator.
      hi_nxt = mul_sum[N:1];
      lo_nxt = {mul_sum[0], acc_lo[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      run      <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc_hi   <= '0;
      acc_lo   <= is_div ? a : b;
      opnd     <= is_div ? b : a;
      div_mode <= is_div;
      run      <= 1'b1;
      cnt      <= '0;
    end else if (run) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        run <= 1'b0;
      end
    end
  end

  assign prod_lo = acc_lo;
  assign prod_hi = acc_hi;
  assign quot    = acc_lo;
  assign rem     = acc_hi;

endmodule

// File: rtl/ripple_carry_adder_N_bits.sv
// N-bit ripple-carry adder with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (addends), cin (carry in), sum, cout (carry out).
module ripple_carry_adder_N_bits #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[N];

endmodule

// File: rtl/alu_seq_n_bits.sv
// Sequential N-bit ALU with start/busy/done handshake and registered result/flags.
// Latency: done 2 cycles after accept for single-cycle ops, N+2 for mul/div/mod.
// Backpressure: start is ignored while busy; nothing is queued.
// Ports: clk, rst_n; start/op/a/b request an operation; busy, done pulse,
// result, flags v/c/n/z, dz (divide by zero), err (illegal opcode).
module alu_seq_n_bits
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    result,
  output logic            v,
  output logic            c,
  output logic            n,
  output logic            z,
  output logic            dz,
  output logic            err
);

  localparam logic [N-1:0] N_VAL = N'(N);

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic [N-1:0]    a_q, b_q;

  logic            accept;
  logic            needs_iter;
  logic            load;
  logic            last;
  logic [N-1:0]    prod_lo, prod_hi, quot, rem;

  logic [N-1:0]    add_b;
  logic [N-1:0]    add_sum;
  logic            add_cout;

  logic [N-1:0]    res_nxt;
  logic            v_nxt, c_nxt, dz_nxt, err_nxt;

  assign accept     = (state == ST_IDLE) && start;
  // Division by zero has a fixed answer, so it skips the iterative unit.
  assign needs_iter = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = needs_iter;
          state_nxt = needs_iter ? ST_ITER : ST_FIN;
        end
      end
      ST_ITER: begin
        if (last) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Loaded straight from the inputs on the accept edge, in step with the latches.
  iter_muldiv #(.N(N)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .is_div  (op != OP_MUL),
    .a       (a),
    .b       (b),
    .last    (last),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi),
    .quot    (quot),
    .rem     (rem)
  );

  // op[0] selects subtract: a + ~b + 1.
  assign add_b = op_q[0] ? ~b_q : b_q;

  ripple_carry_adder_N_bits #(.N(N)) u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (op_q[0]),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res_nxt = '0;
    v_nxt   = 1'b0;
    c_nxt   = 1'b0;
    dz_nxt  = 1'b0;
    err_nxt = op_illegal(op_q);
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_nxt = add_sum;
        c_nxt   = add_cout;
        v_nxt   = (a_q[N-1] == add_b[N-1]) && (add_sum[N-1] != a_q[N-1]);
      end
      OP_AND: res_nxt = a_q & b_q;
      OP_OR:  res_nxt = a_q | b_q;
      OP_XOR: res_nxt = a_q ^ b_q;
      OP_LSR: res_nxt = (b_q >= N_VAL) ? '0 : (a_q >> b_q);
      OP_LSL: res_nxt = (b_q >= N_VAL) ? '0 : (a_q << b_q);
      OP_MOD: begin
        if (b_q == '0) begin
          res_nxt = a_q;
          dz_nxt  = 1'b1;
        end else begin
          res_nxt = rem;
        end
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_nxt = '1;
          dz_nxt  = 1'b1;
        end else begin
          res_nxt = quot;
        end
      end
      OP_MUL: begin
        res_nxt = prod_lo;
        c_nxt   = |prod_hi;
        v_nxt   = |prod_hi;
      end
      default: res_nxt = '0;
    endcase
  end

  // An illegal op yields result 0, so n=0 and z=1 fall out of the common rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      v      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      dz     <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_FIN) begin
        done   <= 1'b1;
        result <= res_nxt;
        v      <= v_nxt;
        c      <= c_nxt;
        n      <= res_nxt[N-1];
        z      <= (res_nxt == '0);
        dz     <= dz_nxt;
        err    <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Directed testbench for alu_seq_n_bits, one N=8 and one N=4 instance.
module tb_alu_seq_n_bits;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8, start4;
  logic [3:0] op8, op4;
  logic [7:0] a8, b8, res8;
  logic [3:0] a4, b4, res4;
  logic       busy8, done8, v8, c8, n8, z8, dz8, err8;
  logic       busy4, done4, v4, c4, n4, z4, dz4, err4;

  int n_checks = 0;
  int n_errors = 0;
  bit use4 = 1'b0;

  logic       o_busy, o_done;
  logic [7:0] o_res;
  logic [5:0] o_fl;

  always #5 clk = ~clk;

  alu_seq_n_bits #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8),
    .v(v8), .c(c8), .n(n8), .z(z8), .dz(dz8), .err(err8)
  );

  alu_seq_n_bits #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4),
    .v(v4), .c(c4), .n(n4), .z(z4), .dz(dz4), .err(err4)
  );

  always_comb begin
    o_busy = use4 ? busy4 : busy8;
    o_done = use4 ? done4 : done8;
    o_res  = use4 ? {4'h0, res4} : res8;
    o_fl   = use4 ? {v4, c4, n4, z4, dz4, err4} : {v8, c8, n8, z8, dz8, err8};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w4, input bit s, input logic [3:0] o,
                       input logic [7:0] x, input logic [7:0] y);
    if (w4) begin
      start4 = s; op4 = o; a4 = x[3:0]; b4 = y[3:0];
    end else begin
      start8 = s; op8 = o; a8 = x; b8 = y;
    end
  endtask

  // Called at a negedge. Flags are {v,c,n,z,dz,err}. With poke set, a stray
  // start is pulsed mid-operation and must be ignored.
  task automatic run_op(input string tag, input bit w4, input logic [3:0] o,
                        input logic [7:0] x, input logic [7:0] y, input int exp_lat,
                        input logic [7:0] exp_res, input logic [5:0] exp_fl,
                        input bit poke);
    int lat;
    use4 = w4;
    drive(w4, 1'b1, o, x, y);
    @(negedge clk);
    drive(w4, 1'b0, 4'd0, 8'hA5, 8'h5A);
    chk({tag, "_busy"}, o_busy, 1);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (o_done || lat >= 60) break;
      drive(w4, poke && (lat == 2), 4'd0, 8'h01, 8'h01);
    end
    drive(w4, 1'b0, 4'd0, 8'h00, 8'h00);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, o_res, exp_res);
    chk({tag, "_flags"}, o_fl, exp_fl);
    chk({tag, "_busy_done"}, o_busy, 0);
  endtask

  initial begin
    bit seen;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    start4 = 0; op4 = 0; a4 = 0; b4 = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst8", {busy8, done8, res8, v8, c8, n8, z8, dz8, err8}, 0);
    chk("rst4", {busy4, done4, res4, v4, c4, n4, z4, dz4, err4}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle8", {busy8, done8, res8, v8, c8, n8, z8, dz8, err8}, 0);

    // N=8 single-cycle ops
    run_op("add_ovf", 0, 4'd0, 8'h7F, 8'h01, 1, 8'h80, 6'b101000, 0);
    @(negedge clk);
    chk("done_pulse", done8, 0);
    run_op("sub_eq",  0, 4'd1, 8'h05, 8'h05, 1, 8'h00, 6'b010100, 0);
    run_op("add_b2b", 0, 4'd0, 8'hFF, 8'h01, 1, 8'h00, 6'b010100, 0);
    @(negedge clk);
    run_op("sub_vovf", 0, 4'd1, 8'h80, 8'h01, 1, 8'h7F, 6'b110000, 0);
    @(negedge clk);

    // Iterative ops
    run_op("mul", 0, 4'd8, 8'h10, 8'h11, 9, 8'h10, 6'b110000, 1);
    @(negedge clk);
    chk("no_queue_busy", busy8, 0);
    chk("no_queue_done", done8, 0);
    run_op("div", 0, 4'd9, 8'd200, 8'd7, 9, 8'd28, 6'b000000, 0);
    @(negedge clk);
    run_op("mod", 0, 4'd7, 8'd200, 8'd7, 9, 8'd4, 6'b000000, 0);
    @(negedge clk);
    run_op("div0", 0, 4'd9, 8'd200, 8'd0, 1, 8'hFF, 6'b001010, 0);
    @(negedge clk);
    run_op("mod0", 0, 4'd7, 8'h2B, 8'd0, 1, 8'h2B, 6'b000010, 0);
    @(negedge clk);
    run_op("xor", 0, 4'd4, 8'hF0, 8'h3C, 1, 8'hCC, 6'b001000, 0);
    @(negedge clk);
    run_op("lsr_big", 0, 4'd5, 8'h80, 8'd8, 1, 8'h00, 6'b000100, 0);
    @(negedge clk);
    run_op("lsr", 0, 4'd5, 8'h80, 8'd3, 1, 8'h10, 6'b000000, 0);
    @(negedge clk);

    // N=4 instance
    run_op("lsl_big4", 1, 4'd6, 8'h3, 8'h5, 1, 8'h0, 6'b000100, 0);
    @(negedge clk);
    run_op("illegal4", 1, 4'd12, 8'h3, 8'h3, 1, 8'h0, 6'b000101, 0);
    @(negedge clk);
    run_op("or_clr4", 1, 4'd3, 8'h3, 8'h4, 1, 8'h7, 6'b000000, 0);
    @(negedge clk);
    run_op("sub_brw4", 1, 4'd1, 8'h3, 8'h5, 1, 8'hE, 6'b001000, 0);
    @(negedge clk);
    run_op("mul4", 1, 4'd8, 8'hF, 8'hF, 5, 8'h1, 6'b110000, 0);
    @(negedge clk);

    // Reset during a division
    use4 = 1'b0;
    drive(0, 1'b1, 4'd9, 8'd200, 8'd7);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst8", {busy8, done8, res8, v8, c8, n8, z8, dz8, err8}, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    run_op("div_after", 0, 4'd9, 8'd200, 8'd7, 9, 8'd28, 6'b000000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
